serial_word_loader: RTL and testbench
=====================================

SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the word width in bits; legal range 1..16.
REQ-002 Parameter MSB_FIRST, default 1, SHALL mean the first serial bit of a frame lands in word_out[WIDTH-1] when 1, and in word_out[0] when 0.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 s_valid  input  1  SHALL indicate that s_data and s_start are valid this cycle.
REQ-006 s_data  input  1  SHALL be the serial data bit.
REQ-007 s_start  input  1  SHALL mark the first bit of a frame; qualified by s_valid.
REQ-008 s_ready  output  1  SHALL indicate the block accepts a bit this cycle; a bit is accepted on a rising edge with s_valid=1 and s_ready=1.
REQ-009 word_out  output  WIDTH  SHALL be the last committed word; it drives the downstream register data input.
REQ-010 wr_en  output  1  SHALL be a one-cycle write strobe; it drives the downstream register rw input.
REQ-011 busy  output  1  SHALL be 1 whenever the state is not IDLE.
REQ-012 frame_err  output  1  SHALL be a one-cycle pulse flagging a discarded or aborted bit/frame.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, COMMIT.
REQ-014 s_ready, word_out, wr_en and frame_err SHALL be registered outputs; busy SHALL be decoded from the state register.
REQ-015 s_ready SHALL be 1 in IDLE and SHIFT, and 0 in COMMIT.
REQ-016 IDLE, accepted bit with s_start=1: the block SHALL load it as bit 1, set the bit count to 1, and go to SHIFT (or to COMMIT if WIDTH=1).
REQ-017 IDLE, accepted bit with s_start=0: the block SHALL discard it, stay in IDLE, and pulse frame_err for one cycle.
REQ-018 SHIFT, accepted bit with s_start=0: the block SHALL shift it in and increment the bit count.
REQ-019 SHIFT, accepted bit with s_start=1: the block SHALL discard the partial frame, pulse frame_err, and restart with this bit as bit 1 (count=1).
REQ-020 When the accepted bit is bit WIDTH, the block SHALL, on that same edge, load word_out with the complete frame, set wr_en=1 and s_ready=0, and enter COMMIT.
REQ-021 COMMIT SHALL last exactly one cycle; on the next edge wr_en=0, s_ready=1, and the state returns to IDLE.
REQ-022 Latency: wr_en SHALL be high in the cycle after the last bit is accepted, so the downstream register captures word_out one edge after the last bit.
REQ-023 word_out SHALL change only on a commit; partial frames SHALL never be visible on word_out.
REQ-024 s_valid=0 SHALL freeze the shift state and the bit count; there is no timeout.
REQ-025 Bits are never accepted in COMMIT (s_ready=0); the source SHALL hold s_valid and s_data until accepted.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never exceed WIDTH.
REQ-027 With WIDTH=1, an accepted start bit SHALL commit directly (IDLE -> COMMIT).

Reset
REQ-028 Asserting rst_n low SHALL immediately force: state=IDLE, bit count=0, shift register=0, word_out=0, wr_en=0, frame_err=0, s_ready=0.
REQ-029 s_ready SHALL rise on the first clk rising edge after rst_n is released.
REQ-030 A reset asserted mid-frame or during COMMIT SHALL discard the frame, and no wr_en pulse SHALL follow.

Verification
REQ-031 WIDTH=4, MSB_FIRST=1, bits 1,0,1,1 (s_start on the first bit), back-to-back -> word_out=4'b1011, wr_en high exactly 1 cycle, in the cycle after the 4th acceptance.
REQ-032 MSB_FIRST=0, same bits -> word_out=4'b1101.
REQ-033 Frame 1,0 then s_start with bits 0,1,1,0 -> frame_err pulse at the restart, then word_out=4'b0110, a single wr_en pulse.
REQ-034 Bit with s_start=0 while IDLE -> frame_err 1 cycle, busy stays 0, word_out unchanged.
REQ-035 s_valid toggling 1,0,0,1,... within a frame of 1,1,0,0 -> word_out=4'b1100; in COMMIT s_ready=0 and a held s_valid bit is accepted only after the return to IDLE.
REQ-036 rst_n pulled low after 3 bits of a frame -> all outputs at reset values immediately, no wr_en; a fresh frame 0,1,0,1 after release -> word_out=4'b0101.

Source files
------------

// File: rtl/serial_word_loader.sv
// Serial-to-parallel frame loader: assembles WIDTH framed serial bits into a word and
// issues a one-cycle write strobe to a downstream register when the frame is complete.
module serial_word_loader #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             s_start,
    output logic             s_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             wr_en,
    output logic             busy,
    output logic             frame_err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shift_q;

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_next;

    // A start bit always begins from an empty register, so restarts never leak old bits.
    always_comb begin
        base = s_start ? '0 : shift_q;
        if (MSB_FIRST) begin
            shifted = (base << 1) | WIDTH'(s_data);
        end else begin
            shifted = (base >> 1) | (WIDTH'(s_data) << (WIDTH - 1));
        end
        cnt_next = s_start ? CW'(1) : cnt_q + CW'(1);
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            word_out  <= '0;
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            s_ready   <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            s_ready   <= 1'b1;
            case (state_q)
                StIdle, StShift: begin
                    if (s_valid && s_ready) begin
                        if (!s_start && state_q == StIdle) begin
                            frame_err <= 1'b1;
                        end else begin
                            // A start bit arriving mid-frame aborts the partial frame.
                            if (s_start && state_q == StShift) begin
                                frame_err <= 1'b1;
                            end
                            shift_q <= shifted;
                            cnt_q   <= cnt_next;
                            if (cnt_next == CW'(WIDTH)) begin
                                word_out <= shifted;
                                wr_en    <= 1'b1;
                                s_ready  <= 1'b0;
                                state_q  <= StCommit;
                            end else begin
                                state_q <= StShift;
                            end
                        end
                    end
                end
                StCommit: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader: two instances (MSB-first and LSB-first) share stimulus and
// are compared every cycle against a frame-level model built from a queue of received bits.
module tb_serial_word_loader;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic s_data = 1'b0;
    logic s_start = 1'b0;

    logic         rdy_a, wr_a, busy_a, err_a;
    logic [W-1:0] word_a;
    logic         rdy_b, wr_b, busy_b, err_b;
    logic [W-1:0] word_b;

    serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_start(s_start),
        .s_ready(rdy_a), .word_out(word_a), .wr_en(wr_a), .busy(busy_a), .frame_err(err_a)
    );

    serial_word_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_start(s_start),
        .s_ready(rdy_b), .word_out(word_b), .wr_en(wr_b), .busy(busy_b), .frame_err(err_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt_a = 0, wr_cnt_b = 0, err_cnt_a = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: the current frame is a queue of bits; a full queue becomes a word.
    bit         m_ready, m_wr, m_err, m_commit;
    bit         m_q[$];
    logic [W-1:0] m_word_msb, m_word_lsb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 0; m_wr = 0; m_err = 0; m_commit = 0;
            m_q.delete();
            m_word_msb = '0; m_word_lsb = '0;
        end else begin
            m_wr = 0; m_err = 0;
            if (m_commit) begin
                m_commit = 0;
                m_ready  = 1;
            end else begin
                if (s_valid && m_ready) begin
                    if (s_start) begin
                        if (m_q.size() != 0) m_err = 1;
                        m_q.delete();
                        m_q.push_back(s_data);
                    end else if (m_q.size() == 0) begin
                        m_err = 1;
                    end else begin
                        m_q.push_back(s_data);
                    end
                end
                if (m_q.size() == W) begin
                    m_word_msb = '0; m_word_lsb = '0;
                    for (int i = 0; i < W; i++) begin
                        m_word_msb[W-1-i] = m_q[i];
                        m_word_lsb[i]     = m_q[i];
                    end
                    m_q.delete();
                    m_wr = 1; m_commit = 1; m_ready = 0;
                end else begin
                    m_ready = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_a", 32'(rdy_a), 32'(m_ready));
            chk("ready_b", 32'(rdy_b), 32'(m_ready));
            chk("wr_a", 32'(wr_a), 32'(m_wr));
            chk("wr_b", 32'(wr_b), 32'(m_wr));
            chk("err_a", 32'(err_a), 32'(m_err));
            chk("err_b", 32'(err_b), 32'(m_err));
            chk("busy_a", 32'(busy_a), 32'((m_q.size() != 0) || m_commit));
            chk("busy_b", 32'(busy_b), 32'((m_q.size() != 0) || m_commit));
            chk("word_a", 32'(word_a), 32'(m_word_msb));
            chk("word_b", 32'(word_b), 32'(m_word_lsb));
            if (wr_a) wr_cnt_a++;
            if (wr_b) wr_cnt_b++;
            if (err_a) err_cnt_a++;
        end
    end

    task automatic drive(input bit v, input bit d, input bit s);
        @(negedge clk);
        s_valid = v; s_data = d; s_start = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic frame(input logic [W-1:0] bits);
        for (int i = W - 1; i >= 0; i--) drive(1, bits[i], i == W - 1);
    endtask

    // Asserts reset mid-cycle and checks the outputs react without waiting for a clock.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_ready", 32'(rdy_a | rdy_b), 32'(0));
        chk("rst_wr", 32'(wr_a | wr_b), 32'(0));
        chk("rst_err", 32'(err_a | err_b), 32'(0));
        chk("rst_busy", 32'(busy_a | busy_b), 32'(0));
        chk("rst_word_a", 32'(word_a), 32'(0));
        chk("rst_word_b", 32'(word_b), 32'(0));
        s_valid = 0; s_data = 0; s_start = 0;
        @(negedge clk);
        #2 rst_n = 1;
        #1 chk("ready_before_edge", 32'(rdy_a), 32'(0));
    endtask

    int wr0, err0;

    initial begin
        do_reset();
        idle(2);

        // MSB- and LSB-first views of bits 1,0,1,1.
        wr0 = wr_cnt_a;
        frame(4'b1011);
        idle(3);
        chk("f1_word_a", 32'(word_a), 32'h0000000b);
        chk("f1_word_b", 32'(word_b), 32'h0000000d);
        chk("f1_model", 32'(m_word_msb), 32'h0000000b);
        chk("f1_wr_pulses", 32'(wr_cnt_a - wr0), 32'(1));

        // Partial frame 1,0 aborted by a new start.
        wr0 = wr_cnt_a; err0 = err_cnt_a;
        drive(1, 1, 1); drive(1, 0, 0);
        frame(4'b0110);
        idle(3);
        chk("restart_word_a", 32'(word_a), 32'h00000006);
        chk("restart_word_b", 32'(word_b), 32'h00000006);
        chk("restart_wr_pulses", 32'(wr_cnt_a - wr0), 32'(1));
        chk("restart_err_pulses", 32'(err_cnt_a - err0), 32'(1));

        // Stray non-start bit while idle.
        err0 = err_cnt_a;
        drive(1, 1, 0);
        idle(2);
        chk("stray_err_pulses", 32'(err_cnt_a - err0), 32'(1));
        chk("stray_word_a", 32'(word_a), 32'h00000006);
        chk("stray_busy", 32'(busy_a), 32'(0));

        // Gapped valid within 1,1,0,0, then a start bit held through COMMIT.
        drive(1, 1, 1); drive(0, 0, 0); drive(0, 0, 0);
        drive(1, 1, 0); drive(0, 0, 0); drive(1, 0, 0); drive(1, 0, 0);
        drive(1, 1, 1);
        #1 chk("commit_ready_low", 32'(rdy_a), 32'(0));
        drive(1, 1, 1);
        idle(2);
        chk("gap_word_a", 32'(word_a), 32'h0000000c);
        chk("gap_word_b", 32'(word_b), 32'h00000003);
        chk("held_bit_started_frame", 32'(busy_a), 32'(1));

        // Reset after three bits of a frame, then a clean frame.
        wr0 = wr_cnt_a;
        drive(1, 1, 1); drive(1, 1, 0); drive(1, 1, 0);
        do_reset();
        idle(1);
        frame(4'b0101);
        idle(3);
        chk("post_rst_word_a", 32'(word_a), 32'h00000005);
        chk("post_rst_word_b", 32'(word_b), 32'h0000000a);
        chk("post_rst_wr_pulses", 32'(wr_cnt_a - wr0), 32'(1));

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 5) == 0);
            end
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
